// File: rtl/shot_input_controller.sv
// Button front end for the 5x5 battleship board: synchronize/debounce five buttons, move a wrap-around
// cursor and issue paced fire strobes. Optional macro SHOT_CTRL_REPEAT_GUARD_EN refuses shots at MISS/HIT cells.
module shot_input_controller #(
  parameter int ROWS            = 5,
  parameter int COLS            = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 3,
  parameter int MAX_SHOTS       = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  input  logic [1:0] cell_state,
  output logic       shoot,
  output logic [3:0] shootRow,
  output logic [3:0] shootCol,
  output logic [3:0] cursorRow,
  output logic [3:0] cursorCol,
  output logic       busy,
  output logic       reject,
  output logic [7:0] shot_count,
  output logic       game_over
);

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE  = 4;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
  localparam logic [3:0]      ROW_LAST  = 4'(ROWS - 1);
  localparam logic [3:0]      COL_LAST  = 4'(COLS - 1);
  localparam logic [7:0]      SHOTS_MAX = 8'(MAX_SHOTS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FIRE = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;

  logic [4:0]            w_raw;
  logic [4:0]            r_sync1;
  logic [4:0]            r_sync2;
  logic [4:0]            r_db_level;
  logic [4:0]            r_level_d;
  logic [4:0]            r_press;
  logic [4:0][DB_W-1:0]  r_db_cnt;

  logic [3:0]            r_row;
  logic [3:0]            r_col;
  logic [3:0]            w_row_next;
  logic [3:0]            w_col_next;

  logic [1:0]            r_state;
  logic [CD_W-1:0]       r_cd_cnt;
  logic [3:0]            r_shoot_row;
  logic [3:0]            r_shoot_col;
  logic                  r_reject;
  logic [7:0]            r_shot_count;
  logic                  r_game_over;

  logic                  w_up;
  logic                  w_down;
  logic                  w_left;
  logic                  w_right;
  logic                  w_fire_evt;
  logic                  w_guard_refuse;

  assign w_raw = {btn_fire, btn_right, btn_left, btn_down, btn_up};

  // Press events are registered so the FSM and cursor both see them one cycle after the debounced rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every stage, including the per-button counter array, is cleared so reset leaves no stale press.
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_db_level <= '0;
      r_level_d  <= '0;
      r_press    <= '0;
      r_db_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the previous stage's old value.
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_db_level;
      r_press   <= r_db_level & ~r_level_d;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_db_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_level[i] <= r_sync2[i];
          r_db_cnt[i]   <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_up       = r_press[BTN_UP];
  assign w_down     = r_press[BTN_DOWN];
  assign w_left     = r_press[BTN_LEFT];
  assign w_right    = r_press[BTN_RIGHT];
  assign w_fire_evt = r_press[BTN_FIRE];

  always_comb begin
    // NOTE: defaults first so no path leaves these unassigned and infers a latch.
    w_row_next = r_row;
    w_col_next = r_col;
    if (w_up && !w_down) begin
      w_row_next = (r_row == 4'd0) ? ROW_LAST : r_row - 4'd1;
    end else if (w_down && !w_up) begin
      w_row_next = (r_row == ROW_LAST) ? 4'd0 : r_row + 4'd1;
    end
    if (w_left && !w_right) begin
      w_col_next = (r_col == 4'd0) ? COL_LAST : r_col - 4'd1;
    end else if (w_right && !w_left) begin
      w_col_next = (r_col == COL_LAST) ? 4'd0 : r_col + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= w_row_next;
      r_col <= w_col_next;
    end
  end

`ifdef SHOT_CTRL_REPEAT_GUARD_EN
  assign w_guard_refuse = cell_state[1];
`else
  logic w_unused_cell;
  assign w_unused_cell  = ^cell_state;
  assign w_guard_refuse = 1'b0;
`endif

  // The target is latched from the pre-move cursor, so a simultaneous move never shifts the shot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cd_cnt     <= '0;
      r_shoot_row  <= '0;
      r_shoot_col  <= '0;
      r_reject     <= 1'b0;
      r_shot_count <= '0;
      r_game_over  <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fire_evt) begin
            if (r_game_over || w_guard_refuse) begin
              r_reject <= 1'b1;
            end else begin
              r_shoot_row <= r_row;
              r_shoot_col <= r_col;
              r_state     <= S_FIRE;
            end
          end
        end
        S_FIRE: begin
          if (r_shot_count != SHOTS_MAX) r_shot_count <= r_shot_count + 8'd1;
          if (r_shot_count == SHOTS_MAX - 8'd1) r_game_over <= 1'b1;
          r_cd_cnt <= CD_LOAD;
          r_state  <= (COOLDOWN_CYCLES > 0) ? S_COOL : S_IDLE;
        end
        S_COOL: begin
          if (r_cd_cnt == '0) r_state <= S_IDLE;
          else                r_cd_cnt <= r_cd_cnt - CD_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign shoot      = (r_state == S_FIRE);
  assign busy       = (r_state != S_IDLE);
  assign reject     = r_reject;
  assign shootRow   = r_shoot_row;
  assign shootCol   = r_shoot_col;
  assign cursorRow  = r_row;
  assign cursorCol  = r_col;
  assign shot_count = r_shot_count;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_shot_input_controller.sv
// Bench for shot_input_controller: a cycle model driven from button timing rules plus directed scenarios,
// and a second fast-debounce instance for the drop-during-cooldown case.
module tb_shot_input_controller;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int DB   = 4;
  localparam int CD   = 3;
  localparam int MAXS = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;           // {fire, right, left, down, up}
  logic [1:0] cell_state;
  logic       shoot, busy, reject, game_over;
  logic [3:0] shootRow, shootCol, cursorRow, cursorCol;
  logic [7:0] shot_count;

  logic       f_rst, f_fire;
  logic       f_shoot, f_busy, f_reject, f_game_over;
  logic [3:0] f_shootRow, f_shootCol, f_cursorRow, f_cursorCol;
  logic [7:0] f_shot_count;

  always #5 clk = ~clk;

  shot_input_controller #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CYCLES(DB),
                          .COOLDOWN_CYCLES(CD), .MAX_SHOTS(MAXS)) u_dut (
    .clk(clk), .rst(rst),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]), .btn_fire(btn[4]),
    .cell_state(cell_state), .shoot(shoot), .shootRow(shootRow), .shootCol(shootCol),
    .cursorRow(cursorRow), .cursorCol(cursorCol), .busy(busy), .reject(reject),
    .shot_count(shot_count), .game_over(game_over)
  );

  shot_input_controller #(.ROWS(5), .COLS(5), .DEBOUNCE_CYCLES(1),
                          .COOLDOWN_CYCLES(3), .MAX_SHOTS(15)) u_dut_fast (
    .clk(clk), .rst(f_rst),
    .btn_up(1'b0), .btn_down(1'b0), .btn_left(1'b0), .btn_right(1'b0), .btn_fire(f_fire),
    .cell_state(2'b00), .shoot(f_shoot), .shootRow(f_shootRow), .shootCol(f_shootCol),
    .cursorRow(f_cursorRow), .cursorCol(f_cursorCol), .busy(f_busy), .reject(f_reject),
    .shot_count(f_shot_count), .game_over(f_game_over)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Raw level seen by the debouncer lags two edges; a level flips after DB consecutive differing samples;
  // a rise becomes an FSM-visible press two edges later; a shot keeps the block busy 1+CD cycles.
  int m_d1[5], m_d2[5], m_lvl[5], m_run[5], m_p1[5], m_p2[5], m_ev[5];
  int m_row, m_col, m_trow, m_tcol, m_busy_left, m_count;
  bit m_rej, m_valid = 1'b0, m_guard;

  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 5; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_p1[b] = 0; m_p2[b] = 0;
      end
      m_row = 0; m_col = 0; m_trow = 0; m_tcol = 0; m_busy_left = 0; m_count = 0; m_rej = 1'b0;
      m_valid = 1'b1;
    end else begin
      for (int b = 0; b < 5; b++) m_ev[b] = m_p2[b];
`ifdef SHOT_CTRL_REPEAT_GUARD_EN
      m_guard = (cell_state >= 2'd2);
`else
      m_guard = 1'b0;
`endif
      m_rej = 1'b0;
      if (m_busy_left > 0) begin
        if (m_busy_left == 1 + CD && m_count < MAXS) m_count++;
        m_busy_left--;
      end else if (m_ev[4] != 0) begin
        if (m_count == MAXS || m_guard) m_rej = 1'b1;
        else begin
          m_trow = m_row; m_tcol = m_col; m_busy_left = 1 + CD;
        end
      end
      m_row = (m_row + ROWS + m_ev[1] - m_ev[0]) % ROWS;
      m_col = (m_col + COLS + m_ev[3] - m_ev[2]) % COLS;
      for (int b = 0; b < 5; b++) begin
        automatic int cmp  = m_d2[b];
        automatic int rose = 0;
        m_d2[b] = m_d1[b];
        m_d1[b] = int'(btn[b]);
        if (cmp != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_lvl[b] = cmp; m_run[b] = 0; rose = cmp;
          end
        end else m_run[b] = 0;
        m_p2[b] = m_p1[b];
        m_p1[b] = rose;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("shoot",      32'(shoot),      32'(m_busy_left == 1 + CD));
      check("busy",       32'(busy),       32'(m_busy_left > 0));
      check("reject",     32'(reject),     32'(m_rej));
      check("shot_count", 32'(shot_count), 32'(m_count));
      check("game_over",  32'(game_over),  32'(m_count == MAXS));
      check("cursorRow",  32'(cursorRow),  32'(m_row));
      check("cursorCol",  32'(cursorCol),  32'(m_col));
      check("shootRow",   32'(shootRow),   32'(m_trow));
      check("shootCol",   32'(shootCol),   32'(m_tcol));
    end
  end

  // ---------------- event counters ----------------
  int edge_n = 0, n_shoot = 0, n_rej = 0, f_n_shoot = 0, f_n_rej = 0;
  always @(posedge clk) edge_n++;
  always @(negedge clk) begin
    if (shoot === 1'b1)    n_shoot++;
    if (reject === 1'b1)   n_rej++;
    if (f_shoot === 1'b1)  f_n_shoot++;
    if (f_reject === 1'b1) f_n_rej++;
  end

  task automatic press(input logic [4:0] mask, input int hold);
    btn = mask;
    repeat (hold) @(negedge clk);
    btn = 5'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_shoot(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (shoot === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int e0, nb, s0, r0;
    rst = 1'b1; f_rst = 1'b1; btn = 5'b0; f_fire = 1'b0; cell_state = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_shoot",      32'(shoot), 0);
    check("rst_busy",       32'(busy), 0);
    check("rst_cursor",     32'({cursorRow, cursorCol}), 0);
    check("rst_shot_count", 32'(shot_count), 0);
    check("rst_game_over",  32'(game_over), 0);
    rst = 1'b0; f_rst = 1'b0;
    @(negedge clk);

    // Hold fire ~50 cycles: one shot at (0,0), latency edge 7, busy 4 cycles.
    s0 = n_shoot;
    btn[4] = 1'b1;
    e0 = edge_n + 1;
    wait_shoot(20, ok);
    check("first_shoot_seen", 32'(ok), 1);
    check("fire_latency_edge", 32'(edge_n), 32'(e0 + 7));
    check("first_target", 32'({shootRow, shootCol}), 0);
    nb = 0;
    while (busy === 1'b1 && nb < 10) begin
      nb++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(nb), 4);
    check("count_after_first", 32'(shot_count), 1);
    repeat (36) @(negedge clk);
    btn[4] = 1'b0;
    repeat (12) @(negedge clk);
    check("one_shot_per_hold", 32'(n_shoot - s0), 1);

    // Wrap-around moves.
    press(5'b00001, 8);
    check("wrap_up_row", 32'(cursorRow), 4);
    press(5'b00100, 8);
    check("wrap_left_col", 32'(cursorCol), 4);
    press(5'b00010, 8);
    check("wrap_down_row", 32'(cursorRow), 0);

    // Short fire glitch produces nothing.
    s0 = n_shoot;
    btn[4] = 1'b1;
    repeat (2) @(negedge clk);
    btn[4] = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_no_shoot", 32'(n_shoot - s0), 0);

    // Opposing moves cancel.
    press(5'b00011, 8);
    check("updown_cancel", 32'({cursorRow, cursorCol}), 32'({4'd0, 4'd4}));

    // Fire at a HIT cell.
    cell_state = 2'd3;
    s0 = n_shoot; r0 = n_rej;
    press(5'b10000, 8);
`ifdef SHOT_CTRL_REPEAT_GUARD_EN
    check("guard_reject", 32'(n_rej - r0), 1);
    check("guard_no_shoot", 32'(n_shoot - s0), 0);
    check("guard_count", 32'(shot_count), 1);
`else
    check("noguard_shoot", 32'(n_shoot - s0), 1);
    check("noguard_no_reject", 32'(n_rej - r0), 0);
    check("noguard_target", 32'({shootRow, shootCol}), 32'({4'd0, 4'd4}));
    check("noguard_count", 32'(shot_count), 2);
`endif
    cell_state = 2'd0;

    // Reset in the middle of COOLDOWN.
    btn[4] = 1'b1;
    wait_shoot(20, ok);
    check("midrst_shoot_seen", 32'(ok), 1);
    @(negedge clk);
    check("midrst_in_cooldown", 32'({busy, shoot}), 32'(2'b10));
    rst = 1'b1; btn = 5'b0;
    @(negedge clk);
    check("midrst_flags", 32'({shoot, busy, reject, game_over}), 0);
    check("midrst_count", 32'(shot_count), 0);
    check("midrst_positions", 32'({cursorRow, cursorCol, shootRow, shootCol}), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Fire with a simultaneous down move: target is the pre-move cursor.
    press(5'b10010, 8);
    check("move_fire_target_row", 32'(shootRow), 0);
    check("move_fire_cursor_row", 32'(cursorRow), 1);

    // Exhaust the budget, then one refused fire.
    for (int i = 0; i < MAXS - 1; i++) press(5'b10000, 8);
    check("budget_count", 32'(shot_count), 15);
    check("budget_game_over", 32'(game_over), 1);
    s0 = n_shoot; r0 = n_rej;
    press(5'b10000, 8);
    check("over_no_shoot", 32'(n_shoot - s0), 0);
    check("over_reject", 32'(n_rej - r0), 1);
    check("over_count_held", 32'(shot_count), 15);

    // Fast instance: events consumed at edges 4, 6, 8; only the first fires, the others are dropped.
    f_fire = 1'b1; @(negedge clk);
    f_fire = 1'b0; @(negedge clk);
    f_fire = 1'b1; @(negedge clk);
    f_fire = 1'b0; @(negedge clk);
    f_fire = 1'b1; @(negedge clk);
    f_fire = 1'b0;
    repeat (25) @(negedge clk);
    check("fast_single_shoot", 32'(f_n_shoot), 1);
    check("fast_no_reject", 32'(f_n_rej), 0);
    check("fast_count", 32'(f_shot_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shot_input_controller.md
# shot_input_controller

Upstream stage of the 5x5 battleship board: turns five raw push-buttons into cursor movement and validated fire commands. It synchronizes and debounces the buttons, keeps a wrap-around target cursor, and issues a single-cycle `shoot` pulse with a stable `shootRow`/`shootCol` for the board. It enforces a post-shot cooldown and a shot budget.

## Interface
- `ROWS`, default 5: board rows; cursor row range is 0..ROWS-1.
- `COLS`, default 5: board columns; cursor column range is 0..COLS-1.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required to accept a level change (≥1).
- `COOLDOWN_CYCLES`, default 3: cycles spent in COOLDOWN after each shot (≥0).
- `MAX_SHOTS`, default 15: shot budget (1..255).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_fire` in 1 each: raw asynchronous buttons, active-high.
- `cell_state` in 2: board state of the cell under the cursor (0 EMPTY, 1 SHIP, 2 MISS, 3 HIT).
- `shoot` out 1: one-cycle fire strobe to the board.
- `shootRow`, `shootCol` out 4 each: target latched at fire; held until the next fire.
- `cursorRow`, `cursorCol` out 4 each: current cursor position.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `reject` out 1: one-cycle pulse when a fire press is refused.
- `shot_count` out 8: number of shots issued.
- `game_over` out 1: high once `shot_count` == MAX_SHOTS.

## Operation
- **Input path, per button:** 2-flop synchronizer, then debouncer, then rising-edge detector that produces a one-cycle press event.
- **Debouncer:**
  - Holds a debounced level and a counter.
  - If the synchronized value equals the level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the level takes the new value and the counter clears.
- **Cursor:**
  - Up decrements the row, wrapping 0 → ROWS-1. Down increments the row, wrapping ROWS-1 → 0. Left/right act the same way on the column.
  - Opposing events in the same cycle (up+down, or left+right) cancel on that axis.
  - Row and column events apply independently.
  - The cursor moves in every FSM state.
- **FSM states: IDLE, FIRE, COOLDOWN.**
  - **IDLE** + fire event:
    - If `game_over`: pulse `reject` and stay in IDLE.
    - If refused by the guard (see Configuration): pulse `reject` and stay in IDLE.
    - Otherwise: latch `shootRow`/`shootCol` ← cursor and go to FIRE.
  - **FIRE:** `shoot`=1 for exactly this cycle; `shot_count` increments. Next state is COOLDOWN if COOLDOWN_CYCLES>0, else IDLE.
  - **COOLDOWN:** lasts exactly COOLDOWN_CYCLES cycles, then IDLE.
- Fire events arriving in FIRE or COOLDOWN are dropped. They are not queued and do not assert `reject`.
- A cursor move in the same cycle as the accepted fire event does not affect the latched target; the target is the pre-move cursor.
- `shot_count` saturates at MAX_SHOTS.
- `game_over` = (`shot_count` == MAX_SHOTS), registered. Once set it stays set until `rst`.

## Timing
- **Reset values:** all outputs 0; cursor (0,0); FSM in IDLE; synchronizers, debounce levels and counters all 0.
- `rst` asserted mid-operation aborts FIRE/COOLDOWN on the next edge. No `shoot` is produced in the cycle after a reset edge.
- **Fire latency:** raw `btn_fire` first sampled high at edge 0 and held → `shoot` high in the cycle after edge DEBOUNCE_CYCLES+3.
- **Move latency:** a direction button is visible on `cursorRow`/`cursorCol` after the same number of edges.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- **Holding a button:** exactly one event per press. A new event requires a debounced release first.
- **Shot spacing:** minimum spacing between `shoot` pulses is 1+COOLDOWN_CYCLES+1 cycles. This allows the board one cycle to register the hit/miss before the next shot.
- `cell_state` is sampled combinationally in the IDLE cycle that holds the fire event.

## Configuration
- `SHOT_CTRL_REPEAT_GUARD_EN` defined: a fire event while `cell_state` is MISS(2) or HIT(3) is refused. `reject` pulses, no shot is issued, and `shot_count` is unchanged.
- `SHOT_CTRL_REPEAT_GUARD_EN` not defined: `cell_state` is ignored. Re-shooting a resolved cell is issued normally and consumes budget.

## Test plan
- **Reset, then fire:** `rst`, then hold `btn_fire` with defaults → one `shoot` pulse with row=0, col=0 at edge 7; `shot_count`=1; `busy` high for 4 cycles.
- **Wrap-around:** from (0,0) press up once, then left once → cursor (4,4). Press down → (0,4).
- **Debounce:**
  - A 2-cycle fire glitch → no `shoot`.
  - Holding fire for 50 cycles → exactly one `shoot`.
  - Up and down in the same cycle → cursor unchanged.
- **Cooldown and budget:**
  - A fire press during COOLDOWN → dropped, no `reject`.
  - After 15 shots → `game_over`=1, and the next fire gives `reject` with no `shoot`.
- **Guard:** with the macro defined, `cell_state`=3 and fire → `reject`, `shot_count` unchanged. Without the macro → `shoot` issued.
- **Mid-operation reset:** assert `rst` during COOLDOWN → next cycle all outputs 0 and FSM in IDLE.
